camera_wr_burst: RTL and testbench

Upstream write-side buffer for the SDRAM frame store. It accepts camera pixels during the active frame window (`A_sign` high) into an internal FIFO and requests SDRAM write bursts when enough data is buffered. It streams words to the SDRAM controller on demand and flushes a short final burst at end of frame. `sdram_control` consumes its `wr_burst_finish` handshake and the same `A_sign` to advance `wr_burst_addr` by one burst slot per finish.

---
 rtl/camera_wr_burst.sv | 136 +++++++++++++
 tb/tb_camera_wr_burst.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_wr_burst.sv
// Camera-side write buffer for the SDRAM frame store: captures pixels during the
// frame window into a FIFO and hands them to the SDRAM controller in bursts.
module camera_wr_burst #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 256,
  parameter int FIFO_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              A_sign,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              wr_burst_req,
  output logic [9:0]        wr_burst_len,
  input  logic              wr_burst_data_req,
  output logic [DATA_W-1:0] wr_burst_data,
  input  logic              wr_burst_finish,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_BURST = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t              state, state_nxt;
  logic                A_sign_d, A_sign_dd;
  logic                sof, eof, frame_on;
  logic                full, empty, push, pop, drop, starve, flush;
  logic                eof_pend;
  logic                load_full, load_part;
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr, wr_addr;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign sof      = A_sign_d & ~A_sign_dd;
  assign eof      = ~A_sign_d & A_sign_dd;
  assign frame_on = A_sign_d;

  assign full   = (fifo_level == LVL_FULL);
  assign empty  = (fifo_level == '0);
  assign push   = pix_valid & frame_on & ~full;
  assign drop   = pix_valid & frame_on & full;
  assign pop    = wr_burst_data_req & ~empty;
  assign starve = wr_burst_data_req & empty;

  // A start of frame while idle discards stale words; a pixel arriving on that
  // same cycle becomes the first word of the fresh FIFO.
  assign flush   = sof & (state == IDLE);
  assign wr_addr = flush ? '0 : wr_ptr;

  assign wr_burst_req = (state == REQ);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    load_full = 1'b0;
    load_part = 1'b0;
    unique case (state)
      IDLE: begin
        if (!sof) begin
          if (fifo_level >= LVL_BURST) begin
            state_nxt = REQ;
            load_full = 1'b1;
          end else if (eof_pend && !empty) begin
            state_nxt = REQ;
            load_part = 1'b1;
          end
        end
      end
      REQ: begin
        if (wr_burst_finish)        state_nxt = IDLE;
        else if (wr_burst_data_req) state_nxt = XFER;
      end
      XFER: begin
        if (wr_burst_finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: FIFO storage is left unreset so it maps onto plain RAM; pointers and level make it empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= pix_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      A_sign_d      <= 1'b0;
      A_sign_dd     <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      wr_burst_data <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      eof_pend      <= 1'b0;
      state         <= IDLE;
      wr_burst_len  <= '0;
    end else begin
      A_sign_d  <= A_sign;
      A_sign_dd <= A_sign_d;

      if (flush) begin
        wr_ptr     <= push ? PTR_ONE : '0;
        rd_ptr     <= '0;
        fifo_level <= push ? LVL_ONE : '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      fifo_level <= fifo_level + LVL_ONE;
        else if (pop && !push) fifo_level <= fifo_level - LVL_ONE;
      end

      if (pop) wr_burst_data <= mem[rd_ptr];

      overflow  <= (overflow & ~sof) | drop;
      underflow <= (underflow & ~sof) | starve;

      if (sof)                            eof_pend <= 1'b0;
      else if (eof)                       eof_pend <= 1'b1;
      else if (state == IDLE && empty)    eof_pend <= 1'b0;

      state <= state_nxt;
      // Short final burst carries whatever is left; it is always below BURST_LEN.
      if (load_full)      wr_burst_len <= 10'(BURST_LEN);
      else if (load_part) wr_burst_len <= 10'(fifo_level);
    end
  end

endmodule

// File: tb/tb_camera_wr_burst.sv
// Self-checking bench for camera_wr_burst: vector table, directed frame scenarios
// and a randomized run compared against a queue-based reference model.
module tb_camera_wr_burst;

  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 256;
  localparam int FIFO_AW   = 10;
  localparam int DEPTH     = 1 << FIFO_AW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              a_sign = 1'b0;
  logic              pix_valid = 1'b0;
  logic [DATA_W-1:0] pix_data = '0;
  logic              wr_burst_req;
  logic [9:0]        wr_burst_len;
  logic              wr_burst_data_req = 1'b0;
  logic [DATA_W-1:0] wr_burst_data;
  logic              wr_burst_finish = 1'b0;
  logic [FIFO_AW:0]  fifo_level;
  logic              overflow;
  logic              underflow;

  camera_wr_burst #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .FIFO_AW(FIFO_AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .A_sign            (a_sign),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .wr_burst_req      (wr_burst_req),
    .wr_burst_len      (wr_burst_len),
    .wr_burst_data_req (wr_burst_data_req),
    .wr_burst_data     (wr_burst_data),
    .wr_burst_finish   (wr_burst_finish),
    .fifo_level        (fifo_level),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] outs();
    return {wr_burst_req, wr_burst_len, wr_burst_data, fifo_level, overflow, underflow};
  endfunction

  // Reference model: the FIFO is a queue, the burst handshake a small phase number.
  bit                m_a1, m_a2, m_ovf, m_unf, m_eofp;
  int                m_phase, m_len;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_q[$];
  bit                model_chk = 1'b0;

  task automatic model_update();
    bit sof, eof, on, idle, push, pop;
    int lvl;
    if (reset) begin
      m_a1 = 0; m_a2 = 0; m_ovf = 0; m_unf = 0; m_eofp = 0;
      m_phase = 0; m_len = 0; m_data = '0; m_q.delete();
    end else begin
      sof  = m_a1 && !m_a2;
      eof  = !m_a1 && m_a2;
      on   = m_a1;
      lvl  = m_q.size();
      idle = (m_phase == 0);
      push = pix_valid && on && lvl < DEPTH;
      pop  = wr_burst_data_req && lvl > 0;
      case (m_phase)
        0: if (!sof) begin
             if (lvl >= BURST_LEN)      begin m_phase = 1; m_len = BURST_LEN; end
             else if (m_eofp && lvl > 0) begin m_phase = 1; m_len = lvl; end
           end
        1: if (wr_burst_finish) m_phase = 0; else if (wr_burst_data_req) m_phase = 2;
        default: if (wr_burst_finish) m_phase = 0;
      endcase
      if (sof)                      m_eofp = 0;
      else if (eof)                 m_eofp = 1;
      else if (idle && lvl == 0)    m_eofp = 0;
      m_ovf = (m_ovf && !sof) || (pix_valid && on && lvl == DEPTH);
      m_unf = (m_unf && !sof) || (wr_burst_data_req && lvl == 0);
      if (pop) m_data = m_q.pop_front();
      if (sof && idle) m_q.delete();
      if (push) m_q.push_back(pix_data);
      m_a2 = m_a1;
      m_a1 = a_sign;
    end
  endtask

  // Stimulus agents: camera stream and SDRAM-controller responder.
  bit                rnd_mode = 0, ctl_en = 0, ctl_hold = 0, ctl_collect = 0;
  int                cam_left = 0, ctl_st = 0, ctl_left = 0, req_cnt = 0, stall_left = 0;
  logic [DATA_W-1:0] cam_val = '0;
  int                len_q[$];
  logic [DATA_W-1:0] rx[$];

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (model_chk)
      check("model_cycle", outs(),
            {m_phase == 1, 10'(m_len), m_data, 11'(m_q.size()), m_ovf, m_unf});
    if (ctl_collect && wr_burst_data_req) rx.push_back(wr_burst_data);

    if (rnd_mode) begin
      if ($urandom_range(0, 249) == 0) a_sign = ~a_sign;
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_data  = DATA_W'($urandom);
      if (stall_left > 0) stall_left--;
      else if ($urandom_range(0, 1499) == 0) stall_left = 1500;
      ctl_hold = (stall_left > 0) || ($urandom_range(0, 3) == 0);
    end else begin
      pix_valid = (cam_left > 0);
      pix_data  = cam_val;
      if (cam_left > 0) begin cam_val++; cam_left--; end
    end

    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b0;
    if (ctl_en) begin
      case (ctl_st)
        0: if (wr_burst_req) begin
             len_q.push_back(int'(wr_burst_len));
             req_cnt++;
             if (rnd_mode && $urandom_range(0, 7) == 0) wr_burst_finish = 1'b1;
             else begin ctl_left = int'(wr_burst_len); ctl_st = 1; end
           end else if (rnd_mode && $urandom_range(0, 39) == 0) begin
             wr_burst_data_req = 1'b1;
           end
        1: if (!ctl_hold) begin
             wr_burst_data_req = 1'b1;
             ctl_left--;
             if (ctl_left == 0) ctl_st = 2;
           end
        default: begin wr_burst_finish = 1'b1; ctl_st = 0; end
      endcase
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; a_sign = 1'b0; pix_valid = 1'b0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    cam_left = 0; ctl_en = 0; ctl_st = 0; ctl_hold = 0; ctl_collect = 0;
    rx.delete(); len_q.delete(); req_cnt = 0;
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();
  endtask

  function automatic int data_errs(input int base, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (i >= rx.size() || rx[i] !== DATA_W'(base + i)) bad++;
    return bad;
  endfunction

  typedef struct {
    bit a, pv; logic [15:0] pd; bit dreq, fin;
    bit req; logic [9:0] len; logic [15:0] data; logic [10:0] lvl; bit ovf, unf;
  } vec_t;

  vec_t vt[13];

  initial begin
    bit done;

    // Short hand-computed sequence: capture lag, pop latency, underflow, 1-word flush.
    vt[0]  = '{1, 1, 16'h0011, 0, 0, 0, 10'd0, 16'h0000, 11'd0, 0, 0};
    vt[1]  = '{1, 1, 16'h0022, 0, 0, 0, 10'd0, 16'h0000, 11'd1, 0, 0};
    vt[2]  = '{1, 1, 16'h0033, 1, 0, 0, 10'd0, 16'h0022, 11'd1, 0, 0};
    vt[3]  = '{1, 0, 16'h0000, 1, 0, 0, 10'd0, 16'h0033, 11'd0, 0, 0};
    vt[4]  = '{1, 0, 16'h0000, 1, 0, 0, 10'd0, 16'h0033, 11'd0, 0, 1};
    vt[5]  = '{0, 1, 16'h0044, 0, 0, 0, 10'd0, 16'h0033, 11'd1, 0, 1};
    vt[6]  = '{0, 1, 16'h0055, 0, 0, 0, 10'd0, 16'h0033, 11'd1, 0, 1};
    vt[7]  = '{0, 0, 16'h0000, 0, 0, 1, 10'd1, 16'h0033, 11'd1, 0, 1};
    vt[8]  = '{0, 0, 16'h0000, 1, 0, 0, 10'd1, 16'h0044, 11'd0, 0, 1};
    vt[9]  = '{0, 0, 16'h0000, 0, 1, 0, 10'd1, 16'h0044, 11'd0, 0, 1};
    vt[10] = '{0, 0, 16'h0000, 0, 0, 0, 10'd1, 16'h0044, 11'd0, 0, 1};
    vt[11] = '{1, 0, 16'h0000, 0, 0, 0, 10'd1, 16'h0044, 11'd0, 0, 1};
    vt[12] = '{1, 0, 16'h0000, 0, 0, 0, 10'd1, 16'h0044, 11'd0, 0, 0};

    repeat (3) step();
    check("reset_state", outs(), 40'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      a_sign = vt[i].a; pix_valid = vt[i].pv; pix_data = vt[i].pd;
      wr_burst_data_req = vt[i].dreq; wr_burst_finish = vt[i].fin;
      step();
      check($sformatf("vec%0d", i), outs(),
            {vt[i].req, vt[i].len, vt[i].data, vt[i].lvl, vt[i].ovf, vt[i].unf});
    end

    // 512-pixel frame: two full bursts, in-order data.
    do_reset();
    ctl_en = 1; ctl_collect = 1; a_sign = 1'b1;
    repeat (3) step();
    cam_val = 0; cam_left = 512;
    for (int i = 0; i < 4000 && !(cam_left == 0 && rx.size() >= 512 && ctl_st == 0); i++) step();
    done = (cam_left == 0 && rx.size() >= 512 && ctl_st == 0);
    check("t1_done", done, 1);
    a_sign = 1'b0;
    repeat (4) step();
    check("t1_req_cnt", req_cnt, 2);
    check("t1_len0", len_q[0], 256);
    check("t1_len1", len_q[1], 256);
    check("t1_rx_count", rx.size(), 512);
    check("t1_data_errs", data_errs(0, 512), 0);
    check("t1_level", fifo_level, 0);

    // 300-pixel frame: full burst then 44-word flush after end of frame.
    do_reset();
    ctl_en = 1; ctl_collect = 1; a_sign = 1'b1;
    repeat (3) step();
    cam_val = 0; cam_left = 300;
    for (int i = 0; i < 1000 && cam_left != 0; i++) step();
    a_sign = 1'b0;
    for (int i = 0; i < 2000 && !(rx.size() >= 300 && ctl_st == 0); i++) step();
    done = (rx.size() >= 300 && ctl_st == 0);
    check("t2_done", done, 1);
    repeat (4) step();
    check("t2_req_cnt", req_cnt, 2);
    check("t2_len0", len_q[0], 256);
    check("t2_len1", len_q[1], 44);
    check("t2_data_errs", data_errs(0, 300), 0);
    check("t2_level", fifo_level, 0);
    check("t2_eof_pend", dut.eof_pend, 0);

    // Stalled controller: FIFO saturates, 1025th pixel sets overflow, next sof clears it.
    do_reset();
    a_sign = 1'b1;
    repeat (3) step();
    cam_val = 0; cam_left = 1024;
    for (int i = 0; i < 1100 && cam_left != 0; i++) step();
    repeat (2) step();
    check("t3_level_1024", fifo_level, 1024);
    check("t3_no_ovf_at_1024", overflow, 0);
    cam_left = 1;
    repeat (3) step();
    check("t3_ovf_1025", overflow, 1);
    cam_left = 5;
    repeat (7) step();
    check("t3_level_sat", fifo_level, 1024);
    check("t3_req_held", wr_burst_req, 1);
    a_sign = 1'b0;
    repeat (3) step();
    a_sign = 1'b1;
    repeat (3) step();
    check("t3_ovf_cleared", overflow, 0);
    check("t3_level_kept", fifo_level, 1024);

    // Three pulls with one word buffered.
    do_reset();
    a_sign = 1'b1;
    repeat (3) step();
    pix_valid = 1'b1; pix_data = 16'hBEEF;
    step();
    check("t4_level1", fifo_level, 1);
    wr_burst_data_req = 1'b1;
    step();
    check("t4_pop1", {wr_burst_data, fifo_level, underflow}, {16'hBEEF, 11'd0, 1'b0});
    wr_burst_data_req = 1'b1;
    step();
    check("t4_pop2", {wr_burst_data, underflow}, {16'hBEEF, 1'b1});
    wr_burst_data_req = 1'b1;
    step();
    check("t4_pop3", {wr_burst_data, underflow}, {16'hBEEF, 1'b1});

    // sof mid-transfer keeps the FIFO; sof in IDLE discards leftovers.
    do_reset();
    ctl_en = 1; ctl_collect = 1; a_sign = 1'b1;
    repeat (3) step();
    cam_val = 0; cam_left = 256;
    for (int i = 0; i < 1000 && !(ctl_st == 1 && ctl_left == 100); i++) step();
    ctl_hold = 1;
    repeat (2) step();
    check("t5_level_100", fifo_level, 100);
    a_sign = 1'b0;
    repeat (3) step();
    a_sign = 1'b1;
    repeat (3) step();
    check("t5_sof_in_xfer", fifo_level, 100);
    ctl_hold = 0;
    for (int i = 0; i < 500 && !(rx.size() >= 256 && ctl_st == 0); i++) step();
    repeat (2) step();
    check("t5_req_cnt", req_cnt, 1);
    check("t5_data_errs", data_errs(0, 256), 0);
    check("t5_level_0", fifo_level, 0);
    ctl_en = 0;
    cam_val = 16'h0100; cam_left = 20;
    for (int i = 0; i < 100 && cam_left != 0; i++) step();
    repeat (2) step();
    check("t5_leftover", fifo_level, 20);
    a_sign = 1'b0;
    step();
    a_sign = 1'b1;
    step();
    check("t5_pre_sof", {wr_burst_req, fifo_level}, {1'b0, 11'd20});
    step();
    check("t5_sof_idle_flush", fifo_level, 0);

    // Reset in the middle of a transfer, then a clean frame.
    do_reset();
    ctl_en = 1; ctl_collect = 1; a_sign = 1'b1;
    repeat (3) step();
    cam_val = 0; cam_left = 256;
    for (int i = 0; i < 1000 && !(ctl_st == 1 && ctl_left == 246); i++) step();
    check("t6_in_xfer", fifo_level != 0, 1);
    reset = 1'b1; cam_left = 0;
    step();
    check("t6_reset_outs", outs(), 40'h0);
    reset = 1'b0; ctl_st = 0; pix_valid = 1'b0; wr_burst_data_req = 1'b0;
    rx.delete(); len_q.delete(); req_cnt = 0;
    repeat (3) step();
    cam_val = 16'd1000; cam_left = 256;
    for (int i = 0; i < 1000 && !(rx.size() >= 256 && ctl_st == 0); i++) step();
    repeat (2) step();
    check("t6_req_cnt", req_cnt, 1);
    check("t6_len", len_q[0], 256);
    check("t6_data_errs", data_errs(1000, 256), 0);
    check("t6_level", fifo_level, 0);

    // Randomized traffic against the reference model.
    do_reset();
    rnd_mode = 1; ctl_en = 1; model_chk = 1; a_sign = 1'b1;
    for (int i = 0; i < 8000 && errors < 40; i++) step();
    model_chk = 0; rnd_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
